// File: rtl/his_peak.sv
// his_peak: depth histogram over a batch of TDC frames, followed by a peak-bin search.
// Define HIS_DUAL_PEAK_EN to also report the second-highest bin as a second output beat.
module his_peak #(
  parameter int DATA_W    = 15,
  parameter int NBINS     = 32,
  parameter int BIN_SHIFT = 10,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              HIS_En,
  input  logic [3:0]        HIS_TH,
  input  logic [15:0]       HIS_Ibatch,
  input  logic [DATA_W-1:0] TDC_Odata,
  input  logic [3:0]        TDC_Oint,
  input  logic              TDC_Ovalid,
  input  logic              TDC_Olast,
  output logic              TDC_Oready,
  output logic [DATA_W-1:0] HIS_Odata,
  output logic [CNT_W-1:0]  HIS_Ocnt,
  output logic              HIS_Ovalid,
  output logic              HIS_Olast,
  input  logic              HIS_Oready
);
  localparam int IDX_W = $clog2(NBINS);
  localparam logic [IDX_W:0] SCAN_END = (IDX_W+1)'(NBINS);
  localparam logic [IDX_W:0] CLR_END  = (IDX_W+1)'(NBINS - 1);

  typedef enum logic [2:0] {IDLE, ACC, SCAN, OUT, CLR} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  bin_q [NBINS];
  logic [3:0]        th_q;
  logic [15:0]       batch_q;
  logic [15:0]       frame_q;
  logic [IDX_W:0]    idx_q;
  logic [IDX_W-1:0]  pk_idx_q;
  logic [CNT_W-1:0]  pk_cnt_q;
`ifdef HIS_DUAL_PEAK_EN
  logic [IDX_W-1:0]  sc_idx_q;
  logic [CNT_W-1:0]  sc_cnt_q;
`endif
  logic              ovalid_q;
  logic              olast_q;
  logic [DATA_W-1:0] odata_q;
  logic [CNT_W-1:0]  ocnt_q;

  logic [DATA_W-1:0] bin_full_d;
  logic [IDX_W-1:0]  bin_sel_d;
  logic              in_range_d;
  logic              accept_d;
  logic              hit_d;
  logic              batch_done_d;
  logic [IDX_W-1:0]  scan_idx_d;
  logic [CNT_W-1:0]  scan_cnt_d;
  logic [15:0]       batch_d;

  // Bin centre for a non-empty bin; an empty histogram reports all ones.
  function automatic logic [DATA_W-1:0] enc(input logic [IDX_W-1:0] idx,
                                            input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] v;
    if (cnt == '0) v = '1;
    else           v = (DATA_W'(idx) << BIN_SHIFT) | (DATA_W'(1) << (BIN_SHIFT - 1));
    return v;
  endfunction

  always_comb begin
    bin_full_d   = TDC_Odata >> BIN_SHIFT;
    bin_sel_d    = bin_full_d[IDX_W-1:0];
    in_range_d   = (32'(bin_full_d) < 32'(NBINS));
    accept_d     = TDC_Ovalid && (state_q == ACC);
    // A beat accepted while HIS_En is falling is consumed but never binned.
    hit_d        = accept_d && HIS_En && (TDC_Oint >= th_q) && in_range_d;
    batch_done_d = accept_d && HIS_En && TDC_Olast && (frame_q == batch_q - 16'd1);
    scan_idx_d   = idx_q[IDX_W-1:0];
    scan_cnt_d   = bin_q[scan_idx_d];
    batch_d      = (HIS_Ibatch == 16'd0) ? 16'd1 : HIS_Ibatch;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
      th_q     <= '0;
      batch_q  <= 16'd1;
      frame_q  <= '0;
      idx_q    <= '0;
      pk_idx_q <= '0;
      pk_cnt_q <= '0;
`ifdef HIS_DUAL_PEAK_EN
      sc_idx_q <= '0;
      sc_cnt_q <= '0;
`endif
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      odata_q  <= '0;
      ocnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (HIS_En) begin
            state_q <= ACC;
            th_q    <= HIS_TH;
            batch_q <= batch_d;
            frame_q <= '0;
          end
        end
        ACC: begin
          if (hit_d && (bin_q[bin_sel_d] != {CNT_W{1'b1}}))
            bin_q[bin_sel_d] <= bin_q[bin_sel_d] + CNT_W'(1);
          if (!HIS_En) begin
            state_q <= CLR;
            idx_q   <= '0;
            frame_q <= '0;
          end else if (batch_done_d) begin
            state_q  <= SCAN;
            idx_q    <= '0;
            frame_q  <= '0;
            pk_idx_q <= '0;
            pk_cnt_q <= '0;
`ifdef HIS_DUAL_PEAK_EN
            sc_idx_q <= '0;
            sc_cnt_q <= '0;
`endif
          end else if (accept_d && TDC_Olast) begin
            frame_q <= frame_q + 16'd1;
          end
        end
        SCAN: begin
          if (!HIS_En) begin
            state_q <= CLR;
            idx_q   <= '0;
          end else if (idx_q == SCAN_END) begin
            // Extra cycle after the last bin registers the encoded result.
            state_q  <= OUT;
            ovalid_q <= 1'b1;
            odata_q  <= enc(pk_idx_q, pk_cnt_q);
            ocnt_q   <= pk_cnt_q;
`ifdef HIS_DUAL_PEAK_EN
            olast_q  <= 1'b0;
`else
            olast_q  <= 1'b1;
`endif
          end else begin
            bin_q[scan_idx_d] <= '0;
            idx_q <= idx_q + (IDX_W+1)'(1);
            if (scan_cnt_d > pk_cnt_q) begin
              pk_cnt_q <= scan_cnt_d;
              pk_idx_q <= scan_idx_d;
`ifdef HIS_DUAL_PEAK_EN
              sc_cnt_q <= pk_cnt_q;
              sc_idx_q <= pk_idx_q;
            end else if (scan_cnt_d > sc_cnt_q) begin
              sc_cnt_q <= scan_cnt_d;
              sc_idx_q <= scan_idx_d;
`endif
            end
          end
        end
        OUT: begin
          if (HIS_Oready) begin
`ifdef HIS_DUAL_PEAK_EN
            if (!olast_q) begin
              odata_q <= enc(sc_idx_q, sc_cnt_q);
              ocnt_q  <= sc_cnt_q;
              olast_q <= 1'b1;
            end else
`endif
            begin
              ovalid_q <= 1'b0;
              if (HIS_En) begin
                state_q <= ACC;
                th_q    <= HIS_TH;
                batch_q <= batch_d;
                frame_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        CLR: begin
          bin_q[scan_idx_d] <= '0;
          if (idx_q == CLR_END) state_q <= IDLE;
          else                  idx_q   <= idx_q + (IDX_W+1)'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TDC_Oready = (state_q == ACC);
  assign HIS_Ovalid = ovalid_q;
  assign HIS_Olast  = olast_q;
  assign HIS_Odata  = odata_q;
  assign HIS_Ocnt   = ocnt_q;

endmodule

// File: tb/tb_his_peak.sv
// Directed bench for his_peak: hand-computed peak results, latency, backpressure and reset/abort cases.
module tb_his_peak;
  localparam int DATA_W = 15;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              HIS_En = 1'b0;
  logic [3:0]        HIS_TH = 4'd5;
  logic [15:0]       HIS_Ibatch = 16'd10;
  logic [DATA_W-1:0] TDC_Odata = '0;
  logic [3:0]        TDC_Oint = '0;
  logic              TDC_Ovalid = 1'b0;
  logic              TDC_Olast = 1'b0;
  logic              TDC_Oready;
  logic [DATA_W-1:0] HIS_Odata;
  logic [CNT_W-1:0]  HIS_Ocnt;
  logic              HIS_Ovalid;
  logic              HIS_Olast;
  logic              HIS_Oready = 1'b0;

  int total = 0;
  int bad = 0;

`ifdef HIS_DUAL_PEAK_EN
  localparam logic FIRST_LAST = 1'b0;
`else
  localparam logic FIRST_LAST = 1'b1;
`endif

  his_peak #(.DATA_W(DATA_W), .NBINS(32), .BIN_SHIFT(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .HIS_En(HIS_En), .HIS_TH(HIS_TH), .HIS_Ibatch(HIS_Ibatch),
    .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Ovalid(TDC_Ovalid),
    .TDC_Olast(TDC_Olast), .TDC_Oready(TDC_Oready),
    .HIS_Odata(HIS_Odata), .HIS_Ocnt(HIS_Ocnt), .HIS_Ovalid(HIS_Ovalid),
    .HIS_Olast(HIS_Olast), .HIS_Oready(HIS_Oready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [3:0] oi, input logic last);
    int n = 0;
    TDC_Odata = d; TDC_Oint = oi; TDC_Olast = last; TDC_Ovalid = 1'b1;
    while (!TDC_Oready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!TDC_Oready) chk("beat_accept_timeout", 64'(TDC_Oready), 64'd1);
    @(posedge clk); #1;
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
  endtask

  task automatic send_frames(input int n, input logic [DATA_W-1:0] d, input logic [3:0] oi);
    for (int i = 0; i < n; i++) send_beat(d, oi, 1'b1);
  endtask

  task automatic take_beat(input string tag, input int d, input int c, input logic last);
    int n = 0;
    while (!HIS_Ovalid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 64'(HIS_Ovalid), 64'd1);
    $display("beat %s: data=%0d cnt=%0d last=%0d", tag, HIS_Odata, HIS_Ocnt, HIS_Olast);
    chk({tag, "_data"}, 64'(HIS_Odata), 64'(d));
    chk({tag, "_cnt"},  64'(HIS_Ocnt),  64'(c));
    chk({tag, "_last"}, 64'(HIS_Olast), 64'(last));
    HIS_Oready = 1'b1;
    @(posedge clk); #1;
    HIS_Oready = 1'b0;
  endtask

  task automatic take_result(input string tag, input int d1, input int c1, input int d2, input int c2);
`ifdef HIS_DUAL_PEAK_EN
    take_beat({tag, "_pk"}, d1, c1, 1'b0);
    take_beat({tag, "_sc"}, d2, c2, 1'b1);
`else
    take_beat(tag, d1, c1, 1'b1);
    if (d2 < 0 || c2 < 0) chk({tag, "_arg"}, 64'd0, 64'd1);
`endif
    chk({tag, "_done"}, 64'(HIS_Ovalid), 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset state
    #1 rstn = 1'b0;
    #10;
    chk("rst_ovalid", 64'(HIS_Ovalid), 64'd0);
    chk("rst_olast",  64'(HIS_Olast),  64'd0);
    chk("rst_odata",  64'(HIS_Odata),  64'd0);
    chk("rst_ocnt",   64'(HIS_Ocnt),   64'd0);
    chk("rst_tready", 64'(TDC_Oready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    HIS_En = 1'b1;

    // 10 frames in bin 9 with latency from the 10th accept edge
    send_frames(9, 15'd10080, 4'd6);
    send_beat(15'd10080, 4'd6, 1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!HIS_Ovalid && lat < 100);
    chk("latency", 64'(lat), 64'd33);
    take_result("bin9", 9728, 10, 16'h7FFF, 0);

    // Tie between bin 7 and bin 3: lowest index wins
    send_frames(5, 15'd7168, 4'd6);
    send_frames(5, 15'd3072, 4'd6);
    take_result("tie", 3584, 5, 7680, 5);

    // Below threshold: empty histogram
    send_frames(10, 15'd10080, 4'd4);
    take_result("below_th", 16'h7FFF, 0, 16'h7FFF, 0);

    // Saturation at 255, Oint equal to threshold counts
    for (int i = 0; i < 300; i++) send_beat(15'd5200, 4'd5, 1'b0);
    send_frames(10, 15'd5200, 4'd5);
    take_result("sat", 5632, 255, 16'h7FFF, 0);

    // Output backpressure for 20 cycles
    send_frames(10, 15'd20000, 4'd15);
    lat = 0;
    while (!HIS_Ovalid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("hold", {HIS_Ovalid, TDC_Oready, HIS_Odata, HIS_Ocnt, HIS_Olast},
          {1'b1, 1'b0, 15'd19968, 8'd10, FIRST_LAST});
      @(posedge clk); #1;
    end
    take_result("hold_out", 19968, 10, 16'h7FFF, 0);

    // Partial batch then reset: partial data discarded
    send_frames(6, 15'd10080, 4'd6);
    rstn = 1'b0;
    #1;
    chk("midrst_ovalid", 64'(HIS_Ovalid), 64'd0);
    chk("midrst_tready", 64'(TDC_Oready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    send_frames(10, 15'd2048, 4'd6);
    take_result("after_rst", 2560, 10, 16'h7FFF, 0);

    // Disable mid-batch: falling-edge beat accepted, bins cleared, no output
    send_frames(3, 15'd12288, 4'd6);
    TDC_Odata = 15'd12288; TDC_Oint = 4'd6; TDC_Olast = 1'b1; TDC_Ovalid = 1'b1;
    HIS_En = 1'b0;
    chk("abort_ready", 64'(TDC_Oready), 64'd1);
    @(posedge clk); #1;
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    chk("abort_ready_low", 64'(TDC_Oready), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | HIS_Ovalid;
    end
    chk("abort_no_out", 64'(seen), 64'd0);
    HIS_En = 1'b1;
    send_frames(10, 15'd2048, 4'd6);
    take_result("after_abort", 2560, 10, 16'h7FFF, 0);

`ifdef HIS_DUAL_PEAK_EN
    send_frames(6, 15'd2048, 4'd6);
    send_frames(4, 15'd20480, 4'd6);
    take_result("dual", 2560, 6, 20992, 4);
`endif

    // Batch size 0 behaves as 1
    HIS_En = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    HIS_Ibatch = 16'd0;
    HIS_En = 1'b1;
    send_frames(1, 15'd10080, 4'd6);
    take_result("batch0", 9728, 1, 16'h7FFF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
